// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its icache.
package inst_fetch_pkg;

  localparam int          ADDR_W                    = 32;
  localparam int          INST_W                    = 32;
  localparam int          ICACHE_INDEX_BITS_DEFAULT = 7;
  localparam logic [31:0] RESET_PC_DEFAULT          = 32'h0000_0000;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  // IDLE: looking up the icache at pc. WAIT: a miss request is outstanding.
  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_WAIT = 1'b1
  } if_state_t;

  // Redirect targets are always word aligned.
  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one word per entry. Combinational hit/data
// lookup so a hit can be delivered in the same cycle; single synchronous fill port.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [29:0] rd_word_addr,
  output logic        rd_hit,
  output inst_t       rd_data,
  input  logic        wr_en,
  input  logic [29:0] wr_word_addr,
  input  inst_t       wr_data
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  logic [DEPTH-1:0]      valid_reg;
  logic [TAG_W-1:0]      tag_mem  [DEPTH];
  inst_t                 data_mem [DEPTH];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;

  assign rd_idx  = rd_word_addr[INDEX_BITS-1:0];
  assign rd_tag  = rd_word_addr[29:INDEX_BITS];
  assign wr_idx  = wr_word_addr[INDEX_BITS-1:0];
  assign wr_tag  = wr_word_addr[29:INDEX_BITS];

  assign rd_hit  = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

  // Valid bits are the only cache state cleared by reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: holds the PC, serves fetches from the icache, and fills misses
// from memctrl over a level-request / done-pulse handshake.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          ICACHE_INDEX_BITS = ICACHE_INDEX_BITS_DEFAULT,
  parameter logic [31:0] RESET_PC          = RESET_PC_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        branch_enable_in,
  input  logic [31:0] branch_address_in,
  output logic        mem_req_out,
  output logic [31:0] mem_address_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out,
  output logic        if_stall_out
);

  if_state_t state_reg, state_next;
  addr_t     pc_reg, pc_next;
  logic      mem_req_reg, mem_req_next;
  addr_t     mem_addr_reg, mem_addr_next;
  logic      discard_reg, discard_next;

  logic      cache_hit;
  inst_t     cache_data;
  logic      fill_en;
  addr_t     branch_target;
  logic      active;

  assign branch_target   = word_align(branch_address_in);
  assign active          = !rst_in && rdy_in;
  assign mem_req_out     = mem_req_reg;
  assign mem_address_out = mem_addr_reg;

  inst_fetch_icache #(
    .INDEX_BITS (ICACHE_INDEX_BITS)
  ) u_icache (
    .clk          (clk_in),
    .srst         (rst_in),
    .rd_word_addr (pc_reg[31:2]),
    .rd_hit       (cache_hit),
    .rd_data      (cache_data),
    .wr_en        (fill_en),
    .wr_word_addr (mem_addr_reg[31:2]),
    .wr_data      (mem_inst_in)
  );

  // FSM state register; rdy_in low freezes it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IF_IDLE;
    end else if (rdy_in) begin
      state_reg <= state_next;
    end
  end

  // Next state: a miss without branch/stall starts a request, done ends it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IF_IDLE: if (!branch_enable_in && !stall_in && !cache_hit) state_next = IF_WAIT;
      IF_WAIT: if (mem_done_in) state_next = IF_IDLE;
      default: state_next = IF_IDLE;
    endcase
  end

  // Outputs and datapath next values; branch beats stall, and a branch during
  // an outstanding request marks the returning word as not deliverable.
  always_comb begin
    pc_next       = pc_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    discard_next  = discard_reg;
    fill_en       = 1'b0;
    valid_out     = 1'b0;
    inst_out      = '0;
    pc_out        = '0;
    if_stall_out  = 1'b0;
    if (active) begin
      case (state_reg)
        IF_IDLE: begin
          if (branch_enable_in) begin
            pc_next = branch_target;
          end else if (cache_hit) begin
            if (!stall_in) begin
              valid_out = 1'b1;
              pc_out    = pc_reg;
              inst_out  = cache_data;
              pc_next   = pc_reg + 32'd4;
            end
          end else begin
            if_stall_out = 1'b1;
            if (!stall_in) begin
              mem_req_next  = 1'b1;
              mem_addr_next = pc_reg;
            end
          end
        end
        IF_WAIT: begin
          if (mem_done_in) begin
            fill_en      = 1'b1;
            mem_req_next = 1'b0;
            discard_next = 1'b0;
            if (branch_enable_in) begin
              pc_next = branch_target;
            end else if (!discard_reg && !stall_in) begin
              valid_out = 1'b1;
              pc_out    = pc_reg;
              inst_out  = mem_inst_in;
              pc_next   = pc_reg + 32'd4;
            end
          end else begin
            if_stall_out = 1'b1;
            if (branch_enable_in) begin
              pc_next      = branch_target;
              discard_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: PC, request handshake and discard flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_reg       <= RESET_PC;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      discard_reg  <= 1'b0;
    end else if (rdy_in) begin
      pc_reg       <= pc_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      discard_reg  <= discard_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level fetch model.
module tb_inst_fetch;

  localparam int DEPTH = 128;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, stall_in, branch_enable_in, mem_done_in;
  logic [31:0] branch_address_in, mem_inst_in;
  logic        mem_req_out, valid_out, if_stall_out;
  logic [31:0] mem_address_out, pc_out, inst_out;

  int checks = 0;
  int errors = 0;

  // Model state: architectural pc, outstanding request, and which full
  // address each cache slot currently holds.
  logic [31:0] m_pc;
  logic        m_waiting;
  logic [31:0] m_addr;
  logic        m_discard;
  logic        m_init = 1'b0;
  logic [31:0] m_line [DEPTH];
  bit          m_vld  [DEPTH];

  inst_fetch dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .stall_in          (stall_in),
    .branch_enable_in  (branch_enable_in),
    .branch_address_in (branch_address_in),
    .mem_req_out       (mem_req_out),
    .mem_address_out   (mem_address_out),
    .mem_done_in       (mem_done_in),
    .mem_inst_in       (mem_inst_in),
    .pc_out            (pc_out),
    .inst_out          (inst_out),
    .valid_out         (valid_out),
    .if_stall_out      (if_stall_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory image as seen by memctrl.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int unsigned slot(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cyc(input logic rst, input logic rdy, input logic stall,
                     input logic br, input logic [31:0] ba, input logic done);
    logic        e_valid, e_stall, stall_known;
    logic [31:0] e_pc, e_inst, tgt;
    logic        hit;
    int unsigned s;
    rst_in            = rst;
    rdy_in            = rdy;
    stall_in          = stall;
    branch_enable_in  = br;
    branch_address_in = ba;
    mem_done_in       = done;
    mem_inst_in       = done ? mem_word(m_addr) : 32'hDEAD_BEEF;
    tgt               = ba & 32'hFFFF_FFFC;
    @(negedge clk_in);
    e_valid = 1'b0; e_stall = 1'b0; e_pc = 32'h0; e_inst = 32'h0; stall_known = 1'b1;
    if (!rst && m_init) begin
      chk("mem_req", {31'h0, mem_req_out}, {31'h0, m_waiting});
      chk("mem_addr", mem_address_out, m_addr);
    end
    if (rst) begin
      m_pc = 32'h0; m_waiting = 1'b0; m_addr = 32'h0; m_discard = 1'b0; m_init = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    end else if (rdy) begin
      if (!m_waiting) begin
        s   = slot(m_pc);
        hit = m_vld[s] && (m_line[s] == m_pc);
        if (br) begin
          m_pc = tgt;
        end else if (hit) begin
          if (!stall) begin
            e_valid = 1'b1; e_pc = m_pc; e_inst = mem_word(m_pc);
            m_pc = m_pc + 32'd4;
          end
        end else if (!stall) begin
          e_stall = 1'b1; m_waiting = 1'b1; m_addr = m_pc;
        end else begin
          stall_known = 1'b0;
        end
      end else if (done) begin
        s = slot(m_addr);
        m_line[s] = m_addr; m_vld[s] = 1'b1; m_waiting = 1'b0;
        $display("fill addr=%08h data=%08h delivered=%0d", m_addr, mem_word(m_addr),
                 !br && !m_discard && !stall);
        if (br) begin
          m_pc = tgt;
        end else if (!m_discard && !stall) begin
          e_valid = 1'b1; e_pc = m_pc; e_inst = mem_word(m_addr);
          m_pc = m_pc + 32'd4;
        end
        m_discard = 1'b0;
      end else begin
        e_stall = 1'b1;
        if (br) begin
          m_pc = tgt; m_discard = 1'b1;
        end
      end
    end
    chk("valid_out", {31'h0, valid_out}, {31'h0, e_valid});
    chk("inst_out", inst_out, e_inst);
    if (e_valid || rst || !rdy) chk("pc_out", pc_out, e_pc);
    if (stall_known) chk("if_stall_out", {31'h0, if_stall_out}, {31'h0, e_stall});
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic branch(input logic [31:0] a);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 1'b0);
  endtask

  // Let an outstanding request wait lat cycles, then complete it.
  task automatic serve(input int lat);
    for (int i = 0; i < lat; i++) idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] base;
    base = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h0;
    if ($urandom_range(0, 49) == 0) base = 32'hFFFF_FF80;
    return base + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b0; branch_enable_in = 1'b0;
    branch_address_in = 32'h0; mem_done_in = 1'b0; mem_inst_in = 32'h0;
    #1;
    // Reset, then cold miss at 0x0 answered after four cycles with 0x13.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    serve(3);
    // Fill 0x4..0xC, then replay 0x0..0xC from the cache.
    idle(); serve(1);
    idle(); serve(2);
    idle(); serve(0);
    branch(32'h0);
    repeat (4) idle();
    // Branch while waiting on 0x10: word cached but discarded, then fetch 0x100.
    idle();
    idle();
    branch(32'h100);
    idle();
    serve(0);
    idle(); serve(2);
    branch(32'h10);
    idle();
    // Stall for three cycles on a hit at 0x4, then release.
    branch(32'h4);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(); idle();
    // Aliasing addresses evict each other.
    branch(32'h200); idle(); serve(1);
    branch(32'h0);   idle(); serve(1);
    idle();
    // Branch coinciding with done: data cached, not delivered.
    branch(32'h20); idle(); idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
    idle(); serve(0);
    branch(32'h20); idle();
    // Stall across completion: fill without delivery, then hit.
    branch(32'h60); idle(); idle();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    idle();
    // rdy_in low mid-wait with a stray done pulse.
    branch(32'h300); idle(); idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    serve(1);
    // PC wrap from the top word, with unaligned redirect bits.
    branch(32'hFFFF_FFFF); idle(); serve(0);
    idle();
    // Reset while a request is outstanding.
    branch(32'h500); idle(); idle();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(); serve(1);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic r_rst, r_rdy, r_st, r_br, r_done;
      r_rst  = ($urandom_range(0, 199) == 0);
      r_rdy  = ($urandom_range(0, 19) != 0);
      r_st   = ($urandom_range(0, 4) == 0);
      r_br   = ($urandom_range(0, 9) == 0);
      r_done = m_waiting && ($urandom_range(0, 2) == 0);
      cyc(r_rst, r_rdy, r_st, r_br, rand_target(), r_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
